// File: rtl/pos_xy_mem.sv
`default_nettype none
// ============================================================================
// Module   : pos_xy_mem
// Purpose  : Placement-node coordinate store. Two single-port arrays (X, Y)
//            of N_NODE entries, cleared by a power-on/reset sweep, serving
//            read, write and swap requests through a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high; restarts the clearing sweep
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid & req_ready at an edge
//   op         in   00 read, 01 write, 10 swap, 11 reserved (rejected)
//   addr_a     in   primary node index
//   addr_b     in   second node index (swap only)
//   wr_x/wr_y  in   write coordinates
//   rsp_valid  out  one-cycle response pulse
//   rd_x/rd_y  out  response coordinates (held between responses)
//   err        out  qualifies rsp_valid; 1 = request rejected
//   busy       out  high whenever the FSM is not idle
// ============================================================================
module pos_xy_mem #(
  parameter int N_NODE = 14,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wr_x,
  input  logic [DATA_W-1:0] wr_y,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rd_x,
  output logic [DATA_W-1:0] rd_y,
  output logic              err,
  output logic              busy
);

  // Index width actually needed to address N_NODE entries.
  localparam int              c_IDX_W  = (N_NODE > 1) ? $clog2(N_NODE) : 1;
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(N_NODE - 1);
  // One extra bit so the bound is representable when N_NODE == 2**ADDR_W.
  localparam logic [ADDR_W:0]   c_NODES = (ADDR_W + 1)'(N_NODE);

  localparam logic [1:0] c_OP_RD   = 2'b00;
  localparam logic [1:0] c_OP_WR   = 2'b01;
  localparam logic [1:0] c_OP_SWAP = 2'b10;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_SWAP_RB = 3'd2,
    S_SWAP_WA = 3'd3,
    S_SWAP_WB = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_mem_x [0:N_NODE-1];
  logic [DATA_W-1:0] r_mem_y [0:N_NODE-1];

  logic [ADDR_W-1:0] r_init_cnt;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [DATA_W-1:0] r_a_x;
  logic [DATA_W-1:0] r_a_y;
  logic [DATA_W-1:0] r_b_x;
  logic [DATA_W-1:0] r_b_y;

  // Single shared storage port: one address, one optional write per cycle.
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [c_IDX_W-1:0] w_mem_idx;
  logic               w_mem_we;
  logic [DATA_W-1:0]  w_mem_wx;
  logic [DATA_W-1:0]  w_mem_wy;
  logic [DATA_W-1:0]  w_mem_rx;
  logic [DATA_W-1:0]  w_mem_ry;

  logic w_accept;
  logic w_a_ok;
  logic w_b_ok;
  logic w_req_ok;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_a_ok   = {1'b0, addr_a} < c_NODES;
  assign w_b_ok   = {1'b0, addr_b} < c_NODES;

  always_comb begin
    w_req_ok = 1'b0;
    case (op)
      c_OP_RD, c_OP_WR: w_req_ok = w_a_ok;
      c_OP_SWAP:        w_req_ok = w_a_ok && w_b_ok;
      default:          w_req_ok = 1'b0;
    endcase
  end

  // Only the low index bits select an entry; out-of-range addresses never
  // reach the port because such requests are rejected before any access.
  assign w_mem_idx = w_mem_addr[c_IDX_W-1:0];
  assign w_mem_rx  = r_mem_x[w_mem_idx];
  assign w_mem_ry  = r_mem_y[w_mem_idx];

  generate
    if (ADDR_W > c_IDX_W) begin : g_addr_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_mem_addr[ADDR_W-1:c_IDX_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state, handshake outputs and storage-port control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_addr_a;
    w_mem_wx    = '0;
    w_mem_wy    = '0;
    case (r_state)
      S_INIT: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_init_cnt;
        if (r_init_cnt == c_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        req_ready  = 1'b1;
        busy       = 1'b0;
        w_mem_addr = addr_a;
        if (w_accept && w_req_ok) begin
          if (op == c_OP_WR) begin
            w_mem_we = 1'b1;
            w_mem_wx = wr_x;
            w_mem_wy = wr_y;
          end
          if (op == c_OP_SWAP) begin
            w_state_nxt = S_SWAP_RB;
          end
        end
      end
      S_SWAP_RB: begin
        w_mem_addr  = r_addr_b;
        w_state_nxt = S_SWAP_WA;
      end
      S_SWAP_WA: begin
        w_mem_addr  = r_addr_a;
        w_mem_we    = 1'b1;
        w_mem_wx    = r_b_x;
        w_mem_wy    = r_b_y;
        w_state_nxt = S_SWAP_WB;
      end
      S_SWAP_WB: begin
        w_mem_addr  = r_addr_b;
        w_mem_we    = 1'b1;
        w_mem_wx    = r_a_x;
        w_mem_wy    = r_a_y;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage. A reset edge suppresses the write so an aborted swap cannot
  // land; the following sweep clears everything regardless.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) begin
      r_mem_x[w_mem_idx] <= w_mem_wx;
      r_mem_y[w_mem_idx] <= w_mem_wy;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: sweep counter, swap holding registers, response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_cnt <= '0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_a_x      <= '0;
      r_a_y      <= '0;
      r_b_x      <= '0;
      r_b_y      <= '0;
      rsp_valid  <= 1'b0;
      err        <= 1'b0;
      rd_x       <= '0;
      rd_y       <= '0;
    end else begin
      rsp_valid <= 1'b0;

      if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end

      if (w_accept) begin
        if (!w_req_ok) begin
          rsp_valid <= 1'b1;
          err       <= 1'b1;
          rd_x      <= '0;
          rd_y      <= '0;
        end else begin
          case (op)
            c_OP_RD: begin
              rsp_valid <= 1'b1;
              err       <= 1'b0;
              rd_x      <= w_mem_rx;
              rd_y      <= w_mem_ry;
            end
            c_OP_WR: begin
              rsp_valid <= 1'b1;
              err       <= 1'b0;
              rd_x      <= wr_x;
              rd_y      <= wr_y;
            end
            default: begin
              // Swap: capture A now; the response carries A's old value.
              r_addr_a <= addr_a;
              r_addr_b <= addr_b;
              r_a_x    <= w_mem_rx;
              r_a_y    <= w_mem_ry;
            end
          endcase
        end
      end

      if (r_state == S_SWAP_RB) begin
        r_b_x <= w_mem_rx;
        r_b_y <= w_mem_ry;
      end

      if (r_state == S_SWAP_WB) begin
        rsp_valid <= 1'b1;
        err       <= 1'b0;
        rd_x      <= r_a_x;
        rd_y      <= r_a_y;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pos_xy_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_pos_xy_mem
// Purpose  : Self-checking bench for pos_xy_mem. A behavioural model (plain
//            arrays plus a response queue keyed by due cycle) predicts every
//            output on every cycle; directed steps add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pos_xy_mem;

  localparam int N  = 14;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    op;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wr_x;
  logic [DW-1:0] wr_y;
  logic          rsp_valid;
  logic [DW-1:0] rd_x;
  logic [DW-1:0] rd_y;
  logic          err;
  logic          busy;

  pos_xy_mem #(.N_NODE(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .rsp_valid (rsp_valid),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model ----------------
  typedef struct {
    int          due;
    logic        e;
    logic [31:0] x;
    logic [31:0] y;
  } rsp_t;

  logic [31:0] m_x [0:N-1];
  logic [31:0] m_y [0:N-1];
  rsp_t        q[$];
  rsp_t        last;
  int          ready_from = BIG;
  bit          in_reset   = 1'b1;
  bit          armed      = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void push(int due, logic e, logic [31:0] x, logic [31:0] y);
    rsp_t r;
    r.due = due; r.e = e; r.x = x; r.y = y;
    q.push_back(r);
  endfunction

  // Model what the DUT does at the accept edge of the request on the inputs.
  task automatic apply_req(int k);
    bit bad;
    logic [31:0] tx, ty;
    bad = (op == 2'b11) || (int'(addr_a) >= N) || (op == 2'b10 && int'(addr_b) >= N);
    if (bad) push(k, 1'b1, 0, 0);
    else if (op == 2'b00) push(k, 1'b0, m_x[addr_a], m_y[addr_a]);
    else if (op == 2'b01) begin
      m_x[addr_a] = wr_x; m_y[addr_a] = wr_y;
      push(k, 1'b0, wr_x, wr_y);
    end else begin
      tx = m_x[addr_a]; ty = m_y[addr_a];
      push(k + 3, 1'b0, tx, ty);
      m_x[addr_a] = m_x[addr_b]; m_y[addr_a] = m_y[addr_b];
      m_x[addr_b] = tx;          m_y[addr_b] = ty;
      ready_from = k + 3;
    end
  endtask

  // Advance one clock edge and update the model for it.
  task automatic cycle();
    bit rdy;
    rdy = !in_reset && (cyc >= ready_from);
    @(posedge clk); #1;
    if (reset) begin
      q.delete();
      ready_from = BIG;
      in_reset   = 1'b1;
      last       = '{due: 0, e: 1'b0, x: 0, y: 0};
      for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; end
    end else if (in_reset) begin
      in_reset   = 1'b0;
      ready_from = cyc + N - 1;
    end else if (req_valid && rdy) begin
      apply_req(cyc);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit exp_rdy;
    bit exp_v;
    if (armed) begin
      exp_rdy = !in_reset && (cyc >= ready_from);
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, !exp_rdy);
      exp_v = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_v = 1'b1;
        last  = q.pop_front();
      end
      chk("rsp_valid", rsp_valid, exp_v);
      chk("rd_x", rd_x, last.x);
      chk("rd_y", rd_y, last.y);
      chk("err", err, last.e);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(logic [1:0] o, int a, int b, logic [31:0] x, logic [31:0] y);
    req_valid = 1'b1; op = o;
    addr_a = AW'(a); addr_b = AW'(b); wr_x = x; wr_y = y;
  endtask

  task automatic no_req();
    req_valid = 1'b0; op = 2'b00; addr_a = '0; addr_b = '0; wr_x = '0; wr_y = '0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    reset = 1'b0;
    do begin
      cycle();
      n++;
    end while (!req_ready && n < 100);
    chk("init_len", n, N);
  endtask

  task automatic read_all(bit expect_zero);
    for (int i = 0; i < N; i++) begin
      set_req(2'b00, i, 0, 0, 0);
      cycle();
      chk("rd_all_valid", rsp_valid, 1);
      chk("rd_all_err", err, 0);
      if (expect_zero) begin
        chk("rd_zero_x", rd_x, 0);
        chk("rd_zero_y", rd_y, 0);
      end
    end
    no_req();
  endtask

  task automatic lit_rsp(string name, logic e, logic [31:0] x, logic [31:0] y);
    chk({name, "_v"}, rsp_valid, 1);
    chk({name, "_e"}, err, e);
    chk({name, "_x"}, rd_x, x);
    chk({name, "_y"}, rd_y, y);
  endtask

  initial begin
    reset = 1'b1;
    no_req();
    last = '{due: 0, e: 1'b0, x: 0, y: 0};

    // Reset held: block stays in INIT.
    cycle();
    armed = 1'b1;
    repeat (3) cycle();
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdx", rd_x, 0);

    wait_init();
    read_all(1'b1);

    // Write then immediate read of node 3.
    set_req(2'b01, 3, 0, 32'h10, 32'h20); cycle();
    lit_rsp("wr3", 1'b0, 32'h10, 32'h20);
    set_req(2'b00, 3, 0, 0, 0); cycle();
    lit_rsp("rd3", 1'b0, 32'h10, 32'h20);

    // Swap 2 <-> 5.
    set_req(2'b01, 2, 0, 1, 2); cycle();
    set_req(2'b01, 5, 0, 3, 4); cycle();
    set_req(2'b10, 2, 5, 0, 0); cycle();
    set_req(2'b00, 2, 0, 0, 0);              // held until accepted
    for (int j = 0; j < 3; j++) begin
      chk("swap_ready_low", req_ready, 0);
      cycle();
    end
    lit_rsp("swap25", 1'b0, 1, 2);
    cycle();
    lit_rsp("rd2", 1'b0, 3, 4);
    set_req(2'b00, 5, 0, 0, 0); cycle();
    lit_rsp("rd5", 1'b0, 1, 2);

    // Rejected requests.
    set_req(2'b00, N, 0, 0, 0); cycle();
    lit_rsp("err_rd", 1'b1, 0, 0);
    chk("err_rd_busy", busy, 0);
    set_req(2'b10, 1, N, 0, 0); cycle();
    lit_rsp("err_swap", 1'b1, 0, 0);
    chk("err_swap_busy", busy, 0);
    set_req(2'b11, 0, 0, 32'h55, 32'h66); cycle();
    lit_rsp("err_op3", 1'b1, 0, 0);
    set_req(2'b01, 31, 0, 32'h77, 32'h88); cycle();
    lit_rsp("err_wr", 1'b1, 0, 0);
    no_req(); cycle();
    chk("hold_rdx", rd_x, 0);
    chk("hold_err", err, 1);

    // Boundary entry, then verify whole memory via the model.
    set_req(2'b01, N - 1, 0, 32'hdead, 32'hbeef); cycle();
    read_all(1'b0);

    // Self-swap of node 7.
    set_req(2'b01, 7, 0, 9, 9); cycle();
    set_req(2'b10, 7, 7, 0, 0); cycle();
    no_req();
    repeat (3) cycle();
    lit_rsp("swap77", 1'b0, 9, 9);
    set_req(2'b00, 7, 0, 0, 0); cycle();
    lit_rsp("rd7", 1'b0, 9, 9);

    // Mixed traffic, checked by the model only.
    for (int i = 0; i < 60; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom_range(0, 3));
      addr_a    = AW'($urandom_range(0, 15));
      addr_b    = AW'($urandom_range(0, 15));
      wr_x      = $urandom;
      wr_y      = $urandom;
      cycle();
    end
    no_req();
    repeat (4) cycle();

    // Reset in the middle of a swap.
    set_req(2'b01, 4, 0, 5, 6); cycle();
    set_req(2'b10, 4, 1, 0, 0); cycle();     // now in SWAP_RB
    no_req(); cycle();                       // now in SWAP_WA
    chk("swap_wa_busy", busy, 1);
    reset = 1'b1;
    cycle();
    chk("abort_rsp", rsp_valid, 0);
    cycle();
    chk("abort_rsp2", rsp_valid, 0);
    wait_init();
    read_all(1'b1);

    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
